// File: rtl/tetris_pkg.sv
// Shared board geometry, cell encoding and row-clear FSM states.
package tetris_pkg;

    localparam int BOARD_ROWS = 20;
    localparam int BOARD_COLS = 10;
    localparam int COL_BITS   = 5;
    localparam int CELL_W     = 2;

    typedef logic [CELL_W-1:0] cell_t;

    localparam cell_t CELL_EMPTY = '0;

    typedef enum logic [2:0] {
        IDLE,
        READ,
        EVAL,
        WRITE,
        NEXT,
        FILL,
        DONE
    } rce_state_t;

endpackage

// File: rtl/row_buffer.sv
// One-row staging buffer: captures a board row as it streams out of the RAM,
// tracks whether every captured cell is occupied, and replays the row by column.
module row_buffer #(
    parameter int COLS       = 10,
    parameter int DATA_WIDTH = 2,
    parameter int IDX_W      = $clog2(COLS)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clr,
    input  logic                  we,
    input  logic [IDX_W-1:0]      wr_idx,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [IDX_W-1:0]      rd_idx,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  all_full
);

    logic [DATA_WIDTH-1:0] cells [COLS];

    // Capture one cell per cycle at the column the read stream has reached.
    // NOTE: the cell array carries no reset; every slot is rewritten before it is replayed.
    always_ff @(posedge clk) begin
        if (we) begin
            cells[wr_idx] <= wr_data;
        end
    end

    // Running "no EMPTY cell seen" flag, re-armed at the start of each row.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            all_full <= 1'b1;
        end else if (clr) begin
            all_full <= 1'b1;
        end else if (we) begin
            // NOTE: non-blocking update so the flag reads its pre-edge value in this expression.
            all_full <= all_full & (wr_data != '0);
        end
    end

    assign rd_data = cells[rd_idx];

endmodule

// File: rtl/row_clear_engine.sv
// Row-clear engine: scans the board bottom-up, drops full rows, compacts the
// survivors downward, refills the vacated top rows with EMPTY and reports the count.
module row_clear_engine #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = tetris_pkg::CELL_W,
    parameter int ROWS       = tetris_pkg::BOARD_ROWS,
    parameter int COLS       = tetris_pkg::BOARD_COLS,
    parameter int COL_BITS   = tetris_pkg::COL_BITS
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    output logic                      busy,
    output logic                      done,
    output logic [$clog2(ROWS+1)-1:0] lines_cleared,
    output logic [ADDR_WIDTH-1:0]     ram_addr_r,
    input  logic [DATA_WIDTH-1:0]     ram_dout,
    output logic                      ram_we,
    output logic [ADDR_WIDTH-1:0]     ram_addr_w,
    output logic [DATA_WIDTH-1:0]     ram_din
);

    import tetris_pkg::*;

    localparam int ROW_BITS = ADDR_WIDTH - COL_BITS;
    localparam int CW       = COL_BITS + 1;      // column counter must also hold COLS
    localparam int CNT_W    = $clog2(ROWS + 1);
    localparam int IDX_W    = $clog2(COLS);

    localparam logic [ROW_BITS-1:0] LAST_ROW = ROW_BITS'(ROWS - 1);
    localparam logic [CW-1:0]       LAST_COL = CW'(COLS - 1);
    localparam logic [CW-1:0]       END_READ = CW'(COLS);   // extra cycle drains the read latency

    rce_state_t          state, nxt_state;
    logic [ROW_BITS-1:0] src, nxt_src;
    logic [ROW_BITS-1:0] dst, nxt_dst;
    logic [CW-1:0]       col, nxt_col;
    logic [CNT_W-1:0]    cnt, nxt_cnt;

    logic                  buf_clr;
    logic                  buf_we;
    logic                  row_full;
    logic [IDX_W-1:0]      cap_idx;
    logic [IDX_W-1:0]      rep_idx;
    logic [DATA_WIDTH-1:0] rep_data;
    logic [COL_BITS-1:0]   rd_col;

    // Read data lags the address by one cycle, so capture lands one column behind.
    assign cap_idx = IDX_W'(col - CW'(1));
    assign rep_idx = IDX_W'(col);
    // Hold the last real column during the drain cycle so unused columns are never addressed.
    assign rd_col  = (col < END_READ) ? col[COL_BITS-1:0] : LAST_COL[COL_BITS-1:0];

    row_buffer #(
        .COLS       (COLS),
        .DATA_WIDTH (DATA_WIDTH),
        .IDX_W      (IDX_W)
    ) u_row_buffer (
        .clk      (clk),
        .reset    (reset),
        .clr      (buf_clr),
        .we       (buf_we),
        .wr_idx   (cap_idx),
        .wr_data  (ram_dout),
        .rd_idx   (rep_idx),
        .rd_data  (rep_data),
        .all_full (row_full)
    );

    // State, pointers and counters; busy/done/lines_cleared are registered status.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            src           <= '0;
            dst           <= '0;
            col           <= '0;
            cnt           <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            lines_cleared <= '0;
        end else begin
            state <= nxt_state;
            src   <= nxt_src;
            dst   <= nxt_dst;
            col   <= nxt_col;
            cnt   <= nxt_cnt;
            busy  <= (nxt_state != IDLE);
            done  <= (state == DONE);
            if (state == DONE) begin
                lines_cleared <= cnt;
            end
        end
    end

    // Next-state, pointer updates and RAM port drive.
    always_comb begin
        // NOTE: every output of this block is defaulted first so no path can infer a latch.
        nxt_state  = state;
        nxt_src    = src;
        nxt_dst    = dst;
        nxt_col    = col;
        nxt_cnt    = cnt;
        buf_clr    = 1'b0;
        buf_we     = 1'b0;
        ram_we     = 1'b0;
        ram_addr_r = {src, rd_col};
        ram_addr_w = {dst, col[COL_BITS-1:0]};
        ram_din    = DATA_WIDTH'(CELL_EMPTY);

        unique case (state)
            IDLE: begin
                if (start) begin
                    nxt_src   = LAST_ROW;
                    nxt_dst   = LAST_ROW;
                    nxt_cnt   = '0;
                    nxt_col   = '0;
                    nxt_state = READ;
                end
            end
            READ: begin
                buf_clr = (col == '0);
                buf_we  = (col != '0);
                if (col == END_READ) begin
                    nxt_col   = '0;
                    nxt_state = EVAL;
                end else begin
                    nxt_col = col + CW'(1);
                end
            end
            EVAL: begin
                if (row_full) begin
                    nxt_cnt   = cnt + CNT_W'(1);
                    nxt_state = NEXT;
                end else if (src == dst) begin
                    // Row already in place; guard keeps dst from wrapping at row 0.
                    if (dst != '0) begin
                        nxt_dst = dst - ROW_BITS'(1);
                    end
                    nxt_state = NEXT;
                end else begin
                    nxt_col   = '0;
                    nxt_state = WRITE;
                end
            end
            WRITE: begin
                ram_we  = 1'b1;
                ram_din = rep_data;
                if (col == LAST_COL) begin
                    nxt_col   = '0;
                    nxt_dst   = dst - ROW_BITS'(1);   // dst > src >= 0 here
                    nxt_state = NEXT;
                end else begin
                    nxt_col = col + CW'(1);
                end
            end
            NEXT: begin
                nxt_col = '0;
                if (src != '0) begin
                    nxt_src   = src - ROW_BITS'(1);
                    nxt_state = READ;
                end else if (cnt != '0) begin
                    nxt_state = FILL;
                end else begin
                    nxt_state = DONE;
                end
            end
            FILL: begin
                ram_we = 1'b1;
                if (col == LAST_COL) begin
                    nxt_col = '0;
                    if (dst == '0) begin
                        nxt_state = DONE;
                    end else begin
                        nxt_dst = dst - ROW_BITS'(1);
                    end
                end else begin
                    nxt_col = col + CW'(1);
                end
            end
            DONE: begin
                nxt_state = IDLE;
            end
            default: begin
                nxt_state = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_row_clear_engine.sv
// Directed bench for row_clear_engine with a 1-cycle registered-read board RAM
// model and a scoreboard of expected compaction results.
module tb_row_clear_engine;

    localparam int ROWS   = 20;
    localparam int COLS   = 10;
    localparam int AW     = 10;
    localparam int DW     = 2;
    localparam int CNT_W  = 5;
    localparam int STRIDE = 32;

    typedef logic [ROWS-1:0][COLS-1:0][DW-1:0] board_t;
    typedef struct {
        int     lines;
        int     writes;
        board_t board;
    } exp_t;

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] lines_cleared;
    logic [AW-1:0]    ram_addr_r;
    logic [DW-1:0]    ram_dout;
    logic             ram_we;
    logic [AW-1:0]    ram_addr_w;
    logic [DW-1:0]    ram_din;

    logic [DW-1:0] mem [0:(1<<AW)-1];
    exp_t          sb [$];

    int total  = 0;
    int passed = 0;
    int failed = 0;
    int we_count;
    int bad_col_writes;
    int done_count;
    int cycles;

    row_clear_engine dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .busy          (busy),
        .done          (done),
        .lines_cleared (lines_cleared),
        .ram_addr_r    (ram_addr_r),
        .ram_dout      (ram_dout),
        .ram_we        (ram_we),
        .ram_addr_w    (ram_addr_w),
        .ram_din       (ram_din)
    );

    always #5 clk = ~clk;

    // Board RAM: registered read, synchronous write.
    always @(posedge clk) begin
        ram_dout <= mem[ram_addr_r];
        if (ram_we) mem[ram_addr_w] <= ram_din;
    end

    // Activity monitor.
    always @(posedge clk) begin
        if (!reset) begin
            if (ram_we) begin
                we_count++;
                if (ram_addr_w[4:0] >= 5'(COLS)) bad_col_writes++;
            end
            if (done) done_count++;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_mem();
        for (int i = 0; i < (1 << AW); i++) mem[i] = '0;
    endtask

    task automatic set_row(input int r, input logic [DW-1:0] v);
        for (int c = 0; c < COLS; c++) mem[r*STRIDE + c] = v;
    endtask

    function automatic board_t snapshot();
        board_t b;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                b[r][c] = mem[r*STRIDE + c];
        return b;
    endfunction

    // Reference compaction: walk bottom-up, keep non-full rows in order.
    function automatic exp_t model(input board_t b);
        exp_t e;
        int   d;
        bit   full;
        e.board  = '0;
        e.lines  = 0;
        e.writes = 0;
        d = ROWS - 1;
        for (int r = ROWS - 1; r >= 0; r--) begin
            full = 1'b1;
            for (int c = 0; c < COLS; c++) if (b[r][c] == '0) full = 1'b0;
            if (full) begin
                e.lines++;
            end else begin
                if (r != d) e.writes += COLS;
                e.board[d] = b[r];
                d--;
            end
        end
        e.writes += e.lines * COLS;
        return e;
    endfunction

    task automatic run_op(input string tag, input bit extra_start);
        exp_t e;
        bit   seen;
        sb.push_back(model(snapshot()));
        we_count       = 0;
        bad_col_writes = 0;
        done_count     = 0;
        seen           = 1'b0;
        cycles         = 0;
        @(negedge clk);
        start = 1'b1;
        while (cycles < 5000 && !seen) begin
            @(posedge clk);
            cycles++;
            #1;
            if (cycles == 1) begin
                start = 1'b0;
                check({tag, "_busy_rise"}, 64'(busy), 64'd1);
            end
            if (extra_start && cycles == 40) start = 1'b1;
            if (extra_start && cycles == 41) start = 1'b0;
            if (done) seen = 1'b1;
        end
        check({tag, "_done_seen"}, 64'(seen), 64'd1);
        check({tag, "_busy_low_at_done"}, 64'(busy), 64'd0);
        e = sb.pop_front();
        check({tag, "_lines"}, 64'(lines_cleared), 64'(e.lines));
        repeat (300) @(posedge clk);
        #1;
        check({tag, "_single_done"}, 64'(done_count), 64'd1);
        check({tag, "_write_count"}, 64'(we_count), 64'(e.writes));
        check({tag, "_unused_col_writes"}, 64'(bad_col_writes), 64'd0);
        check({tag, "_lines_held"}, 64'(lines_cleared), 64'(e.lines));
        for (int r = 0; r < ROWS; r++) begin
            logic [COLS*DW-1:0] obs_row;
            for (int c = 0; c < COLS; c++) obs_row[c*DW +: DW] = mem[r*STRIDE + c];
            check($sformatf("%s_row%0d", tag, r), 64'(obs_row), 64'(e.board[r]));
        end
    endtask

    initial begin
        bit saw_we;

        // Reset state.
        reset = 1'b1;
        start = 1'b0;
        clear_mem();
        #1;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_we", 64'(ram_we), 64'd0);
        check("rst_lines", 64'(lines_cleared), 64'd0);
        check("rst_addr_r", 64'(ram_addr_r), 64'd0);
        check("rst_addr_w", 64'(ram_addr_w), 64'd0);
        check("rst_din", 64'(ram_din), 64'd0);
        repeat (3) @(negedge clk);
        reset = 1'b0;

        // Empty board with sentinels in unused columns.
        clear_mem();
        mem[19*STRIDE + 10] = 2'b11;
        mem[0*STRIDE + 31]  = 2'b01;
        run_op("empty", 1'b0);
        check("empty_latency", 64'(cycles), 64'(ROWS*(COLS+3)+2));
        check("empty_sentinel_a", 64'(mem[19*STRIDE + 10]), 64'd3);
        check("empty_sentinel_b", 64'(mem[0*STRIDE + 31]), 64'd1);

        // One full row at the bottom.
        clear_mem();
        set_row(19, 2'b01);
        mem[18*STRIDE + 3] = 2'b10;
        run_op("one", 1'b0);
        check("one_r19c3", 64'(mem[19*STRIDE + 3]), 64'd2);
        check("one_r19c0", 64'(mem[19*STRIDE + 0]), 64'd0);

        // Two non-adjacent full rows.
        clear_mem();
        set_row(19, 2'b11);
        set_row(17, 2'b10);
        mem[18*STRIDE + 0] = 2'b11;
        mem[16*STRIDE + 9] = 2'b01;
        run_op("two", 1'b0);
        check("two_r19c0", 64'(mem[19*STRIDE + 0]), 64'd3);
        check("two_r18c9", 64'(mem[18*STRIDE + 9]), 64'd1);

        // Four full rows with a patterned row above.
        clear_mem();
        for (int r = 16; r < 20; r++) set_row(r, 2'b01);
        for (int c = 0; c < COLS; c += 2) mem[15*STRIDE + c] = 2'b10;
        run_op("four", 1'b0);
        check("four_r19c8", 64'(mem[19*STRIDE + 8]), 64'd2);
        check("four_r19c9", 64'(mem[19*STRIDE + 9]), 64'd0);

        // Entire board full, with a stray start pulse mid-operation.
        clear_mem();
        for (int r = 0; r < ROWS; r++) set_row(r, 2'b10);
        run_op("all", 1'b1);

        // Reset during WRITE.
        clear_mem();
        set_row(19, 2'b11);
        mem[18*STRIDE + 0] = 2'b11;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start  = 1'b0;
        saw_we = 1'b0;
        for (int i = 0; i < 1000 && !saw_we; i++) begin
            @(posedge clk);
            #1;
            if (ram_we) saw_we = 1'b1;
        end
        check("abort_reached_write", 64'(saw_we), 64'd1);
        #2;
        reset = 1'b1;
        #1;
        check("abort_we", 64'(ram_we), 64'd0);
        check("abort_busy", 64'(busy), 64'd0);
        @(negedge clk);
        reset = 1'b0;

        clear_mem();
        set_row(19, 2'b01);
        mem[18*STRIDE + 3] = 2'b10;
        run_op("after_abort", 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
